// File: rtl/aq_ejpeg_bitpack.sv
`default_nettype none
// ---------------------------------------------------------------------------
// aq_ejpeg_bitpack: JPEG entropy bit packer with 0xFF stuffing, 1-padding, EOI
// Rev 1.0
// ---------------------------------------------------------------------------
module aq_ejpeg_bitpack (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] CodeData,
  input  logic [5:0]  CodeWidth,
  input  logic        CodeValid,
  output logic        CodeReady,
  input  logic        Eoi,
  output logic [31:0] DataOut,
  output logic        DataOutEnable,
  input  logic        DataOutReady,
  output logic [2:0]  DataOutBytes,
  output logic        DataOutLast,
  output logic        Busy
);

  typedef enum logic [2:0] {
    S_RUN    = 3'd0,
    S_PAD    = 3'd1,
    S_DRAIN  = 3'd2,
    S_EOI_FF = 3'd3,
    S_EOI_D9 = 3'd4,
    S_FIN    = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] bitreg_q, bitreg_d;
  logic [6:0]  bitcnt_q, bitcnt_d;
  logic        stuff_q, stuff_d;
  logic [31:0] asm_q, asm_d;
  logic [1:0]  lane_q, lane_d;
  logic [31:0] dout_q, dout_d;
  logic        dval_q, dval_d;
  logic [2:0]  dbytes_q, dbytes_d;
  logic        dlast_q, dlast_d;

  logic        code_ready, accept, eoi_acc, out_free;
  logic        byte_v, is_pop, is_d9, need_out, take, pop;
  logic [7:0]  byte_val;
  logic [6:0]  code_w, app_w, cnt_b;
  logic [31:0] app_data, word;
  logic [63:0] base, mask64, ins;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_RUN;
      bitreg_q <= '0;
      bitcnt_q <= '0;
      stuff_q  <= 1'b0;
      asm_q    <= '0;
      lane_q   <= '0;
      dout_q   <= '0;
      dval_q   <= 1'b0;
      dbytes_q <= 3'd4;
      dlast_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitreg_q <= bitreg_d;
      bitcnt_q <= bitcnt_d;
      stuff_q  <= stuff_d;
      asm_q    <= asm_d;
      lane_q   <= lane_d;
      dout_q   <= dout_d;
      dval_q   <= dval_d;
      dbytes_q <= dbytes_d;
      dlast_q  <= dlast_d;
    end
  end

  always_comb begin
    out_free   = !dval_q || DataOutReady;
    code_w     = (CodeWidth > 6'd32) ? 7'd32 : {1'b0, CodeWidth};
    code_ready = !rst && (state_q == S_RUN) && (bitcnt_q <= 7'd32);
    accept     = code_ready && CodeValid;
    eoi_acc    = code_ready && Eoi;

    // Byte slot source: pending stuff byte, then raw marker, then accumulator.
    byte_v   = 1'b0;
    byte_val = 8'h00;
    is_pop   = 1'b0;
    is_d9    = 1'b0;
    if (stuff_q) begin
      byte_v = 1'b1;
    end else if (state_q == S_EOI_FF) begin
      byte_v   = 1'b1;
      byte_val = 8'hFF;
    end else if (state_q == S_EOI_D9) begin
      byte_v   = 1'b1;
      byte_val = 8'hD9;
      is_d9    = 1'b1;
    end else if (bitcnt_q >= 7'd8) begin
      byte_v   = 1'b1;
      byte_val = bitreg_q[63:56];
      is_pop   = 1'b1;
    end
    need_out = (lane_q == 2'd3) || is_d9;
    take     = byte_v && (!need_out || out_free);
    pop      = take && is_pop;

    app_w    = 7'd0;
    app_data = 32'h0;
    if (accept) begin
      app_w    = code_w;
      app_data = CodeData;
    end else if (state_q == S_PAD && bitcnt_q[2:0] != 3'd0) begin
      app_w    = 7'd8 - {4'd0, bitcnt_q[2:0]};
      app_data = 32'hFF;
    end

    // New bits land directly below the surviving bits after any pop.
    base     = pop ? {bitreg_q[55:0], 8'h00} : bitreg_q;
    cnt_b    = pop ? (bitcnt_q - 7'd8) : bitcnt_q;
    mask64   = ~(64'hFFFF_FFFF_FFFF_FFFF << app_w);
    ins      = (({32'h0, app_data} & mask64) << (7'd64 - app_w)) >> cnt_b;
    bitreg_d = base | ins;
    bitcnt_d = cnt_b + app_w;
    stuff_d  = take ? (is_pop && byte_val == 8'hFF) : stuff_q;

    word     = asm_q | ({24'h0, byte_val} << {lane_q, 3'b000});
    asm_d    = asm_q;
    lane_d   = lane_q;
    dout_d   = dout_q;
    dval_d   = dval_q && !DataOutReady;
    dbytes_d = dbytes_q;
    dlast_d  = dlast_q;
    if (take) begin
      if (need_out) begin
        dout_d   = word;
        dval_d   = 1'b1;
        dbytes_d = {1'b0, lane_q} + 3'd1;
        dlast_d  = is_d9;
        asm_d    = 32'h0;
        lane_d   = 2'd0;
      end else begin
        asm_d  = word;
        lane_d = lane_q + 2'd1;
      end
    end

    state_d = state_q;
    case (state_q)
      S_RUN:    if (eoi_acc) state_d = S_PAD;
      S_PAD:    state_d = S_DRAIN;
      S_DRAIN:  if (bitcnt_q == 7'd0 && !stuff_q) state_d = S_EOI_FF;
      S_EOI_FF: if (take) state_d = S_EOI_D9;
      S_EOI_D9: if (take) state_d = S_FIN;
      S_FIN:    if (dval_q && DataOutReady) state_d = S_RUN;
      default:  state_d = S_RUN;
    endcase
  end

  assign CodeReady     = code_ready;
  assign DataOut       = dout_q;
  assign DataOutEnable = dval_q;
  assign DataOutBytes  = dbytes_q;
  assign DataOutLast   = dlast_q;
  assign Busy          = (state_q != S_RUN) || (bitcnt_q != 7'd0) || stuff_q ||
                         (lane_q != 2'd0) || dval_q;

endmodule
`default_nettype wire
